// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a circular transmit FIFO
// Ports:
//   clk          clock
//   reset_       asynchronous active-low reset
//   baud         one-cycle strobe per bit period
//   txdata       word to enqueue (DATA_BITS wide)
//   tx_valid     txdata valid; accepted when tx_valid && tx_ready
//   tx_ready     FIFO not full (from the registered count)
//   parity_mode  00 none, 01 even, 10 odd, 11 none; latched when a word is popped
//   tx           serial line, idle high
//   busy         serializer not idle
//   fifo_count   occupied FIFO entries
// Optional feature: define UART_TX_PARITY_EN to build the parity state and generator;
// without it parity_mode is ignored and every frame is start + data + stop.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          baud,
  input  logic [DATA_BITS-1:0]          txdata,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          count_q, count_d;
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 push, pop;
`ifdef UART_TX_PARITY_EN
  logic [1:0]           par_q, par_d;
  logic                 par_en, par_bit;
  assign par_en  = par_q == 2'b01 || par_q == 2'b10;
  // even parity is the XOR of the data; odd parity is its complement
  assign par_bit = (par_q == 2'b10) ^ (^shift_q);
`else
  logic                 unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif
  assign tx_ready   = count_q != (AW+1)'(FIFO_DEPTH);
  assign push       = tx_valid && tx_ready;
  // the pop is the IDLE->START transition itself, so no baud is needed to start a frame
  assign pop        = state_q == S_IDLE && count_q != '0;
  assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign busy       = state_q != S_IDLE;
  assign tx         = tx_q;
  assign fifo_count = count_q;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: if (pop) begin
        shift_d = mem_q[rd_q];
        idx_d   = '0;
        stop_d  = 1'b0;
        state_d = S_START;
`ifdef UART_TX_PARITY_EN
        par_d   = parity_mode;
`endif
      end
      S_START: if (baud) begin
        tx_d    = 1'b0;
        state_d = S_DATA;
      end
      S_DATA: if (baud) begin
        tx_d  = shift_q[idx_q];
        idx_d = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud) begin
        tx_d    = par_bit;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (baud) begin
        tx_d   = 1'b1;
        stop_d = stop_q + 1'b1;
        if (stop_q == STOP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end
  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= txdata;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: frame-level reference model checks two UART TX configurations
module tb_uart_tx_fifo;
  logic       clk = 0, reset_ = 0, baud = 0, tx_valid = 0;
  logic [7:0] txd0 = 0;
  logic [6:0] txd1 = 0;
  logic [1:0] parity_mode = 0;
  logic       rdy0, tx0, busy0, rdy1, tx1, busy1;
  logic [2:0] cnt0, cnt1;
  int checks = 0, failures = 0;
  bit cmp_en = 0, brand = 0;
  int bdiv = 16, bcnt = 0;
  bit [15:0] c0, c1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1;
`else
  localparam bit PAR_EN = 0;
`endif

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset_(reset_), .baud(baud), .txdata(txd0), .tx_valid(tx_valid),
    .tx_ready(rdy0), .parity_mode(parity_mode), .tx(tx0), .busy(busy0), .fifo_count(cnt0));
  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_(reset_), .baud(baud), .txdata(txd1), .tx_valid(tx_valid),
    .tx_ready(rdy1), .parity_mode(parity_mode), .tx(tx1), .busy(busy1), .fifo_count(cnt1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (brand) baud = ($urandom_range(0, 3) == 0);
    else begin
      baud = (bcnt == bdiv - 1);
      bcnt = (bcnt + 1) % bdiv;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int db(input int i); return i == 0 ? 8 : 7; endfunction
  function automatic int sb(input int i); return i == 0 ? 1 : 2; endfunction

  // model: FIFO as an array of words; a popped word becomes a list of line levels,
  // one consumed per baud strobe after the pop cycle
  int m_cnt[2], m_rd[2], m_wr[2], m_pos[2], m_len[2];
  int m_fifo[2][4];
  bit m_busy[2], m_tx[2];
  bit m_lv[2][16];
  bit mpush, mpop;
  int mw;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_pos[i] = 0; m_len[i] = 0;
        m_busy[i] = 0; m_tx[i] = 1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mpush = tx_valid && m_cnt[i] < 4;
        mpop = 0;
        if (!m_busy[i] && m_cnt[i] > 0) begin
          mw = m_fifo[i][m_rd[i]];
          m_rd[i] = (m_rd[i] + 1) % 4;
          mpop = 1;
          m_busy[i] = 1;
          m_pos[i] = 0;
          m_lv[i][0] = 0;
          m_len[i] = 1;
          for (int b = 0; b < db(i); b++) begin
            m_lv[i][m_len[i]] = ((mw >> b) & 1) != 0;
            m_len[i]++;
          end
          if (PAR_EN && (parity_mode == 2'b01 || parity_mode == 2'b10)) begin
            m_lv[i][m_len[i]] = (^mw) ^ (parity_mode == 2'b10);
            m_len[i]++;
          end
          for (int s = 0; s < sb(i); s++) begin
            m_lv[i][m_len[i]] = 1;
            m_len[i]++;
          end
        end else if (m_busy[i] && baud) begin
          m_tx[i] = m_lv[i][m_pos[i]];
          m_pos[i]++;
          if (m_pos[i] == m_len[i]) m_busy[i] = 0;
        end
        if (mpush) begin
          m_fifo[i][m_wr[i]] = i == 0 ? int'(txd0) : int'(txd1);
          m_wr[i] = (m_wr[i] + 1) % 4;
        end
        m_cnt[i] += int'(mpush) - int'(mpop);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("tx0", tx0, m_tx[0]);
      chk("busy0", busy0, m_busy[0]);
      chk("cnt0", cnt0, m_cnt[0]);
      chk("rdy0", rdy0, m_cnt[0] < 4);
      chk("tx1", tx1, m_tx[1]);
      chk("busy1", busy1, m_busy[1]);
      chk("cnt1", cnt1, m_cnt[1]);
      chk("rdy1", rdy1, m_cnt[1] < 4);
    end
  end

  task automatic baud_edge();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!baud && n < 400);
    #1;
    chk("baud_seen", baud, 1);
  endtask

  task automatic push1(input int v0, input int v1);
    @(negedge clk);
    tx_valid = 1; txd0 = 8'(v0); txd1 = 7'(v1);
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic capture(input int n, input int chg);
    c0 = 0; c1 = 0;
    for (int k = 0; k < n; k++) begin
      baud_edge();
      c0[k] = tx0;
      c1[k] = tx1;
      if (k == 0 && chg >= 0) parity_mode = 2'(chg);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy[0] || m_cnt[0] != 0 || m_busy[1] || m_cnt[1] != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", int'(n < 5000), 1);
    chk("drain_busy0", busy0, 0);
    chk("drain_cnt0", cnt0, 0);
    chk("drain_busy1", busy1, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    reset_ = 1;
    @(posedge clk);
    #1;
    chk("rst_tx0", tx0, 1);
    chk("rst_rdy0", rdy0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_cnt1", cnt1, 0);

    parity_mode = 2'b00;
    baud_edge();
    push1(8'hA5, 7'h55);
    capture(10, -1);
    chk("frame_a5", int'(c0[9:0]), 10'b1101001010);
    chk("frame_55_7b2s", int'(c1[9:0]), 10'b1110101010);
    chk("busy_after_stop0", busy0, 0);
    chk("busy_after_stop1", busy1, 0);
    baud_edge();
    chk("idle_line0", tx0, 1);

    baud_edge();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tx_valid = 1; txd0 = 8'($urandom); txd1 = 7'($urandom);
    end
    @(posedge clk);
    #1;
    chk("burst_cnt0", cnt0, 4);
    chk("burst_rdy0", rdy0, 0);
    chk("burst_busy0", busy0, 1);
    chk("burst_cnt1", cnt1, 4);
    chk("burst_rdy1", rdy1, 0);
    repeat (400) begin
      @(negedge clk);
      txd0 = 8'($urandom); txd1 = 7'($urandom);
    end
    tx_valid = 0;
    drain();

    parity_mode = 2'b01;
    baud_edge();
    push1(8'h07, 7'h07);
    capture(11, -1);
    chk("frame_even_07", int'(c0[10:0]), 11'b11000001110);
    drain();
    parity_mode = 2'b10;
    baud_edge();
    push1(8'h07, 7'h07);
    capture(11, 0);
    chk("frame_odd_07", int'(c0[10:0]), PAR_EN ? 11'b10000001110 : 11'b11000001110);
    drain();

    parity_mode = 2'b00;
    baud_edge();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tx_valid = 1; txd0 = 0; txd1 = 0;
    end
    @(negedge clk);
    tx_valid = 0;
    repeat (5) baud_edge();
    chk("bit3_low0", tx0, 0);
    chk("queued_cnt0", cnt0, 2);
    #2;
    reset_ = 0;
    #1;
    chk("arst_tx0", tx0, 1);
    chk("arst_busy0", busy0, 0);
    chk("arst_cnt0", cnt0, 0);
    chk("arst_tx1", tx1, 1);
    chk("arst_cnt1", cnt1, 0);
    repeat (3) @(negedge clk);
    reset_ = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_tx0", tx0, 1);
    chk("post_rst_busy0", busy0, 0);

    brand = 1;
    repeat (20000) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 3) == 0);
      txd0 = 8'($urandom); txd1 = 7'($urandom);
      if ($urandom_range(0, 63) == 0) parity_mode = 2'($urandom);
    end
    brand = 0;
    bdiv = 3;
    repeat (3000) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 15) == 0);
      txd0 = 8'($urandom); txd1 = 7'($urandom);
    end
    tx_valid = 0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, configurable data width, stop-bit count and runtime-selectable parity. It sits between a byte-producing host and the serial pin, and shares the system baud-enable strobe with the receiver. The host pushes words through a valid/ready handshake and never waits on frame completion unless the FIFO is full.

## Interface

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, sent LSB first.
- STOP_BITS, 1: stop bits per frame, legal 1 or 2.
- FIFO_DEPTH, 4: FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset_  in  1  reset, asynchronous, active-low.
- baud  in  1  one-cycle baud-enable strobe, one pulse per bit period.
- txdata  in  DATA_BITS  word to enqueue.
- tx_valid  in  1  txdata is valid this cycle.
- tx_ready  out  1  FIFO not full; a push is accepted when tx_valid && tx_ready.
- parity_mode  in  2  parity selection: 00 none, 01 even, 10 odd, 11 none.
- tx  out  1  serial line, idle high.
- busy  out  1  serializer not in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation

- FIFO:
  - Circular buffer with wrap-around read and write pointers.
  - Push when tx_valid && tx_ready. A push while full cannot occur because tx_ready is low.
  - Pop happens only on the serializer's IDLE→START transition.
  - Push and pop in the same cycle: fifo_count is unchanged and both succeed. This includes the full case, because tx_ready is derived from the registered count.
- Serializer states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if fifo_count != 0, load the head into the shift register, latch parity_mode, clear the bit index, pop, and go to START. No baud is needed for this transition.
  - START: on baud, tx←0, go to DATA.
  - DATA: on baud, tx←shift[idx] and idx++. On the baud where idx == DATA_BITS-1, go to PARITY if the latched mode is even/odd, otherwise go to STOP.
  - PARITY: on baud, tx←^data for even, ~^data for odd, then go to STOP.
  - STOP: on baud, tx←1 and the stop counter increments. After STOP_BITS baud strobes, go to IDLE.
- With no baud strobe, state, tx and index hold.
- parity_mode changes mid-frame have no effect; the value latched at pop is used.
- busy = (state != IDLE).

## Timing

- Reset values: tx=1, tx_ready=1, busy=0, fifo_count=0, state IDLE, FIFO pointers 0.
- Reset is asynchronous:
  - Mid-frame reset forces tx high immediately.
  - Queued data is discarded.
- Push at edge N: fifo_count increments at N.
- If the serializer is idle, START is entered and the entry popped at edge N+1. busy rises after N+1.
- The start bit appears on tx at the first baud strobe at or after edge N+2.
- Each line level persists from one baud strobe to the next.
- Frame length = 1 + DATA_BITS + P + STOP_BITS baud periods, where P is 1 with parity and 0 otherwise.
- Back-to-back frames:
  - IDLE→START happens one clk after the final stop strobe.
  - The next start bit waits for the following baud strobe, so line idle time is always the configured stop length.
- tx_ready falls on the edge where fifo_count reaches FIFO_DEPTH. It rises on the edge after the pop.

## Configuration

- UART_TX_PARITY_EN defined: PARITY state and parity generation are compiled in, and parity_mode is honoured.
- UART_TX_PARITY_EN undefined:
  - The PARITY state, parity latch and parity generator are absent.
  - The parity_mode port remains but is ignored.
  - Every frame is start + DATA_BITS + stop.

## Test plan

- Defaults, parity_mode=00, push 0xA5, baud every 16 clk → tx sequence is 0,1,0,1,0,0,1,0,1,1, one level per baud period. busy falls after the stop strobe.
- UART_TX_PARITY_EN, parity_mode=01 then 10, push 0x07 each time → parity bit is 1 for even and 0 for odd, placed after bit 7. Frame is 11 periods.
- FIFO_DEPTH=4, push 6 words on consecutive cycles with tx_valid held high:
  - 5 are accepted: one is popped at edge N+1, leaving 4 queued.
  - tx_ready drops with fifo_count=4.
  - All accepted words are transmitted in order with no gaps beyond the stop bit.
- Push on the same cycle the serializer pops from a full FIFO → fifo_count stays 4 and no word is lost.
- DATA_BITS=7, STOP_BITS=2, push 0x55 → frame is 0,1,0,1,0,1,0,1,1,1, i.e. 10 periods, with the line high for 2 periods before the next start.
- Assert reset_ during data bit 3 with 2 words queued → tx=1 immediately, fifo_count=0, busy=0. After release, tx stays high until a new push.
